// File: rtl/in_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : in_load_ctrl
// Description : Frame load controller for the 7-lane input shift register.
//               Loads N1 words per frame, then holds the frame and services
//               row-shift requests until the decoder releases it.
// Revision    : 1.0 - initial release
// ============================================================================
module in_load_ctrl #(
    parameter  int N1 = 200,
    parameter  int N2 = 7,
    localparam int CW = $clog2(N1)
) (
    input  logic          Clock,
    input  logic          nReset,
    input  logic          InValid,
    input  logic [N2-1:0] InData,
    output logic          InReady,
    input  logic          ShiftReq,
    input  logic          FrameDone,
    input  logic          Flush,
    output logic [N2-1:0] ShIn,
    output logic          SelShift,
    output logic          SelKeep,
    output logic          FrameReady,
    output logic [CW-1:0] WordCnt,
    output logic          ShiftOvr
);

    localparam int RW = (N2 > 1) ? $clog2(N2) : 1;

    localparam logic [0:0] S_LOAD = 1'b0;
    localparam logic [0:0] S_FULL = 1'b1;

    localparam logic [CW-1:0] c_last_word = CW'(N1 - 1);
    localparam logic [RW-1:0] c_last_row  = RW'(N2 - 1);

    logic [0:0]    r_state,     w_state_nxt;
    logic [CW-1:0] r_word_cnt,  w_word_cnt_nxt;
    logic [RW-1:0] r_row_cnt,   w_row_cnt_nxt;
    logic [N2-1:0] r_sh_in,     w_sh_in_nxt;
    logic          r_sel_shift, w_sel_shift_nxt;
    logic          r_sel_keep,  w_sel_keep_nxt;
    logic          r_shift_ovr, w_shift_ovr_nxt;
    logic          w_handshake;

    assign InReady     = (r_state == S_LOAD) && !Flush;
    assign FrameReady  = (r_state == S_FULL);
    assign w_handshake = InValid && InReady;

    assign ShIn     = r_sh_in;
    assign SelShift = r_sel_shift;
    assign SelKeep  = r_sel_keep;
    assign WordCnt  = r_word_cnt;
    assign ShiftOvr = r_shift_ovr;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state     <= S_LOAD;
            r_word_cnt  <= '0;
            r_row_cnt   <= '0;
            r_sh_in     <= '0;
            r_sel_shift <= 1'b0;
            r_sel_keep  <= 1'b1;
            r_shift_ovr <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
            r_row_cnt   <= w_row_cnt_nxt;
            r_sh_in     <= w_sh_in_nxt;
            r_sel_shift <= w_sel_shift_nxt;
            r_sel_keep  <= w_sel_keep_nxt;
            r_shift_ovr <= w_shift_ovr_nxt;
        end
    end

    // Idle default is "hold", so no word or row shift leaks downstream.
    always_comb begin
        w_state_nxt     = r_state;
        w_word_cnt_nxt  = r_word_cnt;
        w_row_cnt_nxt   = r_row_cnt;
        w_sh_in_nxt     = r_sh_in;
        w_sel_shift_nxt = 1'b0;
        w_sel_keep_nxt  = 1'b1;
        w_shift_ovr_nxt = r_shift_ovr;

        if (Flush) begin
            w_state_nxt     = S_LOAD;
            w_word_cnt_nxt  = '0;
            w_row_cnt_nxt   = '0;
            w_shift_ovr_nxt = 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_handshake) begin
                        w_sh_in_nxt    = InData;
                        w_sel_keep_nxt = 1'b0;
                        if (r_word_cnt == c_last_word) begin
                            w_word_cnt_nxt = '0;
                            w_state_nxt    = S_FULL;
                        end else begin
                            w_word_cnt_nxt = r_word_cnt + 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (FrameDone) begin
                        w_state_nxt   = S_LOAD;
                        w_row_cnt_nxt = '0;
                    end else if (ShiftReq) begin
                        if (r_row_cnt < c_last_row) begin
                            w_sel_keep_nxt  = 1'b0;
                            w_sel_shift_nxt = 1'b1;
                            w_row_cnt_nxt   = r_row_cnt + 1'b1;
                        end else begin
                            w_shift_ovr_nxt = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = S_LOAD;
            endcase
        end
    end

endmodule
`default_nettype wire
